// File: rtl/exc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : exc_ctrl_if
//  Description : MEM-stage exception inputs and cp0/fetch commit outputs of
//                the exception controller, bundled as one interface.
//  Revision    : 1.0  initial release
// ============================================================================
interface exc_ctrl_if #(
    parameter int EXCT_W = 5
);
    logic              mem_valid_i;
    logic              mem_stall_i;
    logic [31:0]       mem_pc_i;
    logic              mem_inslot_i;
    logic [31:0]       mem_daddr_i;
    logic              exc_adel_if_i;
    logic              exc_ri_i;
    logic              exc_ov_i;
    logic              exc_sysc_i;
    logic              exc_bp_i;
    logic              exc_eret_i;
    logic              exc_adel_ld_i;
    logic              exc_ades_i;
    logic              intr_i;
    logic [31:0]       status_i;
    logic [31:0]       epc_i;
    logic              cp0_exc_flag_o;
    logic [EXCT_W-1:0] cp0_exc_type_o;
    logic [31:0]       cp0_pc_o;
    logic [31:0]       cp0_baddr_o;
    logic              cp0_inslot_o;
    logic              flush_o;
    logic              redirect_o;
    logic [31:0]       redirect_pc_o;

    modport master (
        output mem_valid_i, mem_stall_i, mem_pc_i, mem_inslot_i, mem_daddr_i,
               exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sysc_i, exc_bp_i,
               exc_eret_i, exc_adel_ld_i, exc_ades_i, intr_i, status_i, epc_i,
        input  cp0_exc_flag_o, cp0_exc_type_o, cp0_pc_o, cp0_baddr_o,
               cp0_inslot_o, flush_o, redirect_o, redirect_pc_o
    );

    modport slave (
        input  mem_valid_i, mem_stall_i, mem_pc_i, mem_inslot_i, mem_daddr_i,
               exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sysc_i, exc_bp_i,
               exc_eret_i, exc_adel_ld_i, exc_ades_i, intr_i, status_i, epc_i,
        output cp0_exc_flag_o, cp0_exc_type_o, cp0_pc_o, cp0_baddr_o,
               cp0_inslot_o, flush_o, redirect_o, redirect_pc_o
    );
endinterface
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exc_ctrl
//  Description : Fixed-priority exception arbitration and commit to cp0, with
//                pipeline flush and fetch redirect to the vector or EPC.
//  Revision    : 1.0  initial release
// ============================================================================
module exc_ctrl #(
    parameter int          EXCT_W       = 5,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] VEC_BOOT     = 32'hBFC00380,
    parameter logic [31:0] VEC_NORM     = 32'h80000180
) (
    input  logic      clk,
    input  logic      rst,
    exc_ctrl_if.slave bus
);
    // ExcT codes, numbered in priority order (0 = no exception)
    localparam logic [EXCT_W-1:0] c_EXCT_INTR  = EXCT_W'(1);
    localparam logic [EXCT_W-1:0] c_EXCT_ADEL1 = EXCT_W'(2);
    localparam logic [EXCT_W-1:0] c_EXCT_RI    = EXCT_W'(3);
    localparam logic [EXCT_W-1:0] c_EXCT_OV    = EXCT_W'(4);
    localparam logic [EXCT_W-1:0] c_EXCT_SYSC  = EXCT_W'(5);
    localparam logic [EXCT_W-1:0] c_EXCT_BP    = EXCT_W'(6);
    localparam logic [EXCT_W-1:0] c_EXCT_ERET  = EXCT_W'(7);
    localparam logic [EXCT_W-1:0] c_EXCT_ADEL2 = EXCT_W'(8);
    localparam logic [EXCT_W-1:0] c_EXCT_ADES  = EXCT_W'(9);

    localparam int                c_CNT_W    = 3;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;

    logic [EXCT_W-1:0]  r_type;
    logic [31:0]        r_pc;
    logic [31:0]        r_baddr;
    logic               r_inslot;
    logic [31:0]        r_rpc;

    logic               w_any_exc;
    logic               w_candidate;
    logic               w_commit;
    logic [EXCT_W-1:0]  w_type;
    logic [31:0]        w_baddr;
    logic [31:0]        w_rpc;
    logic               w_unused;

    assign w_any_exc   = bus.exc_adel_if_i | bus.exc_ri_i | bus.exc_ov_i |
                         bus.exc_sysc_i | bus.exc_bp_i | bus.exc_eret_i |
                         bus.exc_adel_ld_i | bus.exc_ades_i;
    assign w_candidate = bus.mem_valid_i & (bus.intr_i | w_any_exc);
    assign w_commit    = (r_state == S_IDLE) & w_candidate & ~bus.mem_stall_i;

    // Only Status.BEV is consumed here
    assign w_unused = ^{bus.status_i[31:23], bus.status_i[21:0]};

    always_comb begin
        w_type  = '0;
        w_baddr = '0;
        w_rpc   = bus.status_i[22] ? VEC_BOOT : VEC_NORM;
        if (bus.intr_i) begin
            w_type = c_EXCT_INTR;
        end else if (bus.exc_adel_if_i) begin
            w_type  = c_EXCT_ADEL1;
            w_baddr = bus.mem_pc_i;
        end else if (bus.exc_ri_i) begin
            w_type = c_EXCT_RI;
        end else if (bus.exc_ov_i) begin
            w_type = c_EXCT_OV;
        end else if (bus.exc_sysc_i) begin
            w_type = c_EXCT_SYSC;
        end else if (bus.exc_bp_i) begin
            w_type = c_EXCT_BP;
        end else if (bus.exc_eret_i) begin
            w_type = c_EXCT_ERET;
            w_rpc  = bus.epc_i;
        end else if (bus.exc_adel_ld_i) begin
            w_type  = c_EXCT_ADEL2;
            w_baddr = bus.mem_daddr_i;
        end else if (bus.exc_ades_i) begin
            w_type  = c_EXCT_ADES;
            w_baddr = bus.mem_daddr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_commit) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
            S_FLUSH:  if (r_cnt <= c_CNT_ONE) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Counter holds the FLUSH cycles still to come after the current one + 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_COMMIT) begin
            r_cnt <= c_CNT_LOAD;
        end else if (r_state == S_FLUSH) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_type   <= '0;
            r_pc     <= '0;
            r_baddr  <= '0;
            r_inslot <= 1'b0;
            r_rpc    <= '0;
        end else if (w_commit) begin
            r_type   <= w_type;
            r_pc     <= bus.mem_pc_i;
            r_baddr  <= w_baddr;
            r_inslot <= bus.mem_inslot_i;
            r_rpc    <= w_rpc;
        end
    end

    assign bus.cp0_exc_flag_o = (r_state == S_COMMIT);
    assign bus.redirect_o     = (r_state == S_COMMIT);
    assign bus.flush_o        = (r_state != S_IDLE);
    assign bus.cp0_exc_type_o = r_type;
    assign bus.cp0_pc_o       = r_pc;
    assign bus.cp0_baddr_o    = r_baddr;
    assign bus.cp0_inslot_o   = r_inslot;
    assign bus.redirect_pc_o  = r_rpc;

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_ctrl
//  Description : Directed self-checking bench for exc_ctrl with a cycle model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exc_ctrl;
    localparam int          c_EXCT_W = 5;
    localparam int          c_FLUSH  = 2;
    localparam logic [31:0] c_VBOOT  = 32'hBFC00380;
    localparam logic [31:0] c_VNORM  = 32'h80000180;
    localparam logic [31:0] c_BEV    = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exc_ctrl_if #(.EXCT_W(c_EXCT_W)) ifc ();

    exc_ctrl #(
        .EXCT_W      (c_EXCT_W),
        .FLUSH_CYCLES(c_FLUSH),
        .VEC_BOOT    (c_VBOOT),
        .VEC_NORM    (c_VNORM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_flags  = 0;
    int f0;

    // Model state: expected outputs and remaining flush cycles
    int          m_left   = 0;
    logic        m_flag   = 1'b0;
    logic [4:0]  m_type   = '0;
    logic [31:0] m_pc     = '0;
    logic [31:0] m_baddr  = '0;
    logic        m_inslot = 1'b0;
    logic [31:0] m_rpc    = '0;
    bit          m_ev[9];
    int          m_win;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear();
        ifc.mem_valid_i   = 1'b0; ifc.mem_stall_i   = 1'b0;
        ifc.mem_pc_i      = '0;   ifc.mem_inslot_i  = 1'b0;
        ifc.mem_daddr_i   = '0;   ifc.exc_adel_if_i = 1'b0;
        ifc.exc_ri_i      = 1'b0; ifc.exc_ov_i      = 1'b0;
        ifc.exc_sysc_i    = 1'b0; ifc.exc_bp_i      = 1'b0;
        ifc.exc_eret_i    = 1'b0; ifc.exc_adel_ld_i = 1'b0;
        ifc.exc_ades_i    = 1'b0; ifc.intr_i        = 1'b0;
        ifc.status_i      = '0;   ifc.epc_i         = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clear();
        end
    endtask

    // Behavioural model: priority is the first set entry of an ordered table
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_left = 0; m_flag = 1'b0; m_type = '0; m_pc = '0;
                m_baddr = '0; m_inslot = 1'b0; m_rpc = '0;
            end else begin
                m_ev[0] = ifc.intr_i;     m_ev[1] = ifc.exc_adel_if_i;
                m_ev[2] = ifc.exc_ri_i;   m_ev[3] = ifc.exc_ov_i;
                m_ev[4] = ifc.exc_sysc_i; m_ev[5] = ifc.exc_bp_i;
                m_ev[6] = ifc.exc_eret_i; m_ev[7] = ifc.exc_adel_ld_i;
                m_ev[8] = ifc.exc_ades_i;
                m_win = -1;
                for (int i = 8; i >= 0; i--) if (m_ev[i]) m_win = i;
                m_flag = 1'b0;
                if (m_left == 0 && ifc.mem_valid_i && !ifc.mem_stall_i && m_win >= 0) begin
                    m_flag   = 1'b1;
                    m_left   = c_FLUSH;
                    m_type   = 5'(m_win + 1);
                    m_pc     = ifc.mem_pc_i;
                    m_inslot = ifc.mem_inslot_i;
                    m_baddr  = (m_win == 1) ? ifc.mem_pc_i :
                               (m_win == 7 || m_win == 8) ? ifc.mem_daddr_i : 32'h0;
                    m_rpc    = (m_win == 6) ? ifc.epc_i :
                               (ifc.status_i[22] ? c_VBOOT : c_VNORM);
                end else if (m_left > 0) begin
                    m_left--;
                end
            end
        end
    end

    // Compare process: every cycle, on the falling edge
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("flag",     32'(ifc.cp0_exc_flag_o), 32'(m_flag));
            chk("redirect", 32'(ifc.redirect_o),     32'(m_flag));
            chk("flush",    32'(ifc.flush_o),        32'(m_left > 0));
            chk("type",     32'(ifc.cp0_exc_type_o), 32'(m_type));
            chk("cp0_pc",   ifc.cp0_pc_o,            m_pc);
            chk("baddr",    ifc.cp0_baddr_o,         m_baddr);
            chk("inslot",   32'(ifc.cp0_inslot_o),   32'(m_inslot));
            chk("rpc",      ifc.redirect_pc_o,       m_rpc);
            if (ifc.cp0_exc_flag_o === 1'b1) n_flags++;
        end
    end

    initial begin
        clear();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flag",  32'(ifc.cp0_exc_flag_o), 32'd0);
        chk("rst_flush", 32'(ifc.flush_o),        32'd0);
        chk("rst_rpc",   ifc.redirect_pc_o,       32'h0);
        @(negedge clk); rst = 1'b0;
        idle(2);

        // Syscall, BEV=1
        @(negedge clk);
        ifc.mem_valid_i = 1'b1; ifc.mem_pc_i = 32'hBFC00100;
        ifc.exc_sysc_i = 1'b1;  ifc.status_i = c_BEV;
        @(posedge clk); #1;
        chk("sysc_flag",  32'(ifc.cp0_exc_flag_o), 32'd1);
        chk("sysc_type",  32'(ifc.cp0_exc_type_o), 32'd5);
        chk("sysc_pc",    ifc.cp0_pc_o,            32'hBFC00100);
        chk("sysc_rpc",   ifc.redirect_pc_o,       32'hBFC00380);
        chk("sysc_flush", 32'(ifc.flush_o),        32'd1);
        @(negedge clk); clear();
        @(posedge clk); #1;
        chk("sysc_flag2",  32'(ifc.cp0_exc_flag_o), 32'd0);
        chk("sysc_flush2", 32'(ifc.flush_o),        32'd1);
        chk("sysc_hold",   32'(ifc.cp0_exc_type_o), 32'd5);
        @(posedge clk); #1;
        chk("sysc_flush3", 32'(ifc.flush_o),        32'd0);
        idle(2);

        // Store address error, BEV=0, in a delay slot
        @(negedge clk);
        ifc.mem_valid_i = 1'b1; ifc.mem_pc_i = 32'h80000200; ifc.mem_inslot_i = 1'b1;
        ifc.mem_daddr_i = 32'h80000003; ifc.exc_ades_i = 1'b1;
        @(posedge clk); #1;
        chk("ades_type",   32'(ifc.cp0_exc_type_o), 32'd9);
        chk("ades_baddr",  ifc.cp0_baddr_o,         32'h80000003);
        chk("ades_rpc",    ifc.redirect_pc_o,       32'h80000180);
        chk("ades_inslot", 32'(ifc.cp0_inslot_o),   32'd1);
        idle(3);

        // ERET together with an interrupt: interrupt wins
        @(negedge clk);
        ifc.mem_valid_i = 1'b1; ifc.mem_pc_i = 32'h80000300;
        ifc.exc_eret_i = 1'b1;  ifc.intr_i = 1'b1; ifc.epc_i = 32'h80001234;
        @(posedge clk); #1;
        chk("ei_type",  32'(ifc.cp0_exc_type_o), 32'd1);
        chk("ei_rpc",   ifc.redirect_pc_o,       32'h80000180);
        chk("ei_baddr", ifc.cp0_baddr_o,         32'h0);
        idle(3);

        // ERET alone redirects to EPC
        @(negedge clk);
        ifc.mem_valid_i = 1'b1; ifc.mem_pc_i = 32'h80000300;
        ifc.exc_eret_i = 1'b1;  ifc.epc_i = 32'h80001234;
        @(posedge clk); #1;
        chk("eret_type", 32'(ifc.cp0_exc_type_o), 32'd7);
        chk("eret_rpc",  ifc.redirect_pc_o,       32'h80001234);
        idle(3);

        // Overflow held off by a 3-cycle stall
        f0 = n_flags;
        @(negedge clk);
        ifc.mem_valid_i = 1'b1; ifc.mem_pc_i = 32'h80000400;
        ifc.exc_ov_i = 1'b1;    ifc.mem_stall_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_flag",  32'(ifc.cp0_exc_flag_o), 32'd0);
            chk("stall_flush", 32'(ifc.flush_o),        32'd0);
        end
        @(negedge clk); ifc.mem_stall_i = 1'b0;
        @(posedge clk); #1;
        chk("ov_flag", 32'(ifc.cp0_exc_flag_o), 32'd1);
        chk("ov_type", 32'(ifc.cp0_exc_type_o), 32'd4);
        idle(4);
        chk("ov_once", 32'(n_flags - f0), 32'd1);

        // RI presented during FLUSH is ignored
        f0 = n_flags;
        @(negedge clk);
        ifc.mem_valid_i = 1'b1; ifc.mem_pc_i = 32'h80000500; ifc.exc_sysc_i = 1'b1;
        @(posedge clk);
        @(negedge clk); clear();
        @(posedge clk);
        @(negedge clk);
        ifc.mem_valid_i = 1'b1; ifc.mem_pc_i = 32'h80000504; ifc.exc_ri_i = 1'b1;
        idle(4);
        chk("ri_ignored", 32'(n_flags - f0), 32'd1);

        // Interrupt waits for a valid instruction
        @(negedge clk); ifc.intr_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("intr_novalid", 32'(ifc.cp0_exc_flag_o), 32'd0);
        end
        @(negedge clk); ifc.mem_valid_i = 1'b1; ifc.mem_pc_i = 32'h80000040;
        @(posedge clk); #1;
        chk("intr_flag", 32'(ifc.cp0_exc_flag_o), 32'd1);
        chk("intr_type", 32'(ifc.cp0_exc_type_o), 32'd1);
        chk("intr_pc",   ifc.cp0_pc_o,            32'h80000040);
        idle(3);

        // Reset during FLUSH, then fetch address error
        @(negedge clk);
        ifc.mem_valid_i = 1'b1; ifc.mem_pc_i = 32'h80000600; ifc.exc_sysc_i = 1'b1;
        @(posedge clk);
        @(negedge clk); clear();
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_flag",  32'(ifc.cp0_exc_flag_o), 32'd0);
        chk("mrst_flush", 32'(ifc.flush_o),        32'd0);
        chk("mrst_redir", 32'(ifc.redirect_o),     32'd0);
        chk("mrst_type",  32'(ifc.cp0_exc_type_o), 32'd0);
        chk("mrst_pc",    ifc.cp0_pc_o,            32'h0);
        chk("mrst_rpc",   ifc.redirect_pc_o,       32'h0);
        @(negedge clk);
        rst = 1'b0;
        ifc.mem_valid_i = 1'b1; ifc.mem_pc_i = 32'h00000001; ifc.exc_adel_if_i = 1'b1;
        @(posedge clk); #1;
        chk("adel_flag",  32'(ifc.cp0_exc_flag_o), 32'd1);
        chk("adel_type",  32'(ifc.cp0_exc_type_o), 32'd2);
        chk("adel_baddr", ifc.cp0_baddr_o,         32'h00000001);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
